// File: rtl/seq_calc_unit.sv
// Multi-cycle keypad calculator: decimal digit conversion followed by
// single-cycle add/sub or iterative shift-add multiply / restoring divide.
module seq_calc_unit #(
    parameter int         NDIG   = 2,
    parameter int         OW     = 7,
    parameter int         RW     = 14,
    parameter logic [7:0] OP_ADD = 8'h2B,
    parameter logic [7:0] OP_SUB = 8'h2D,
    parameter logic [7:0] OP_MUL = 8'h2A,
    parameter logic [7:0] OP_DIV = 8'h2F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        op,
    input  logic [NDIG*8-1:0] a_dig,
    input  logic [NDIG*8-1:0] b_dig,
    output logic              busy,
    output logic              done,
    output logic [RW-1:0]     result,
    output logic [OW-1:0]     remainder,
    output logic              neg,
    output logic              err_div0,
    output logic              err_dig,
    output logic              err_op
);

    localparam int CW = $clog2(OW + NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_EXEC,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        op_q;
    logic [NDIG*8-1:0] a_q, b_q;
    logic [OW-1:0]     acc_a, acc_b;
    logic [OW-1:0]     quo, rem;
    logic [RW-1:0]     mcand, prod;
    logic [CW-1:0]     cnt;

    logic [7:0]    da, db;
    logic          bad_a, bad_b;
    logic [OW-1:0] acc_a_nxt, acc_b_nxt;
    logic          is_add, is_sub, is_mul, is_div, op_ok;
    logic          conv_last, exec_last, short_path;
    logic [OW:0]   sum_ab;
    logic          a_ge_b;
    logic [OW-1:0] diff_ab;
    logic [RW-1:0] prod_nxt;
    logic [OW:0]   shl;
    logic          q_bit;
    logic [OW-1:0] dif, rem_nxt, quo_nxt;

    // Digits are consumed from the top byte, most significant first.
    always_comb begin
        da        = a_q[NDIG*8-1 -: 8];
        db        = b_q[NDIG*8-1 -: 8];
        bad_a     = da > 8'd9;
        bad_b     = db > 8'd9;
        acc_a_nxt = acc_a * OW'(10) + (bad_a ? '0 : OW'(da));
        acc_b_nxt = acc_b * OW'(10) + (bad_b ? '0 : OW'(db));
    end

    always_comb begin
        is_add     = op_q == OP_ADD;
        is_sub     = op_q == OP_SUB;
        is_mul     = op_q == OP_MUL;
        is_div     = op_q == OP_DIV;
        op_ok      = is_add | is_sub | is_mul | is_div;
        conv_last  = cnt == CW'(NDIG - 1);
        exec_last  = cnt == CW'(OW - 1);
        short_path = err_dig | ~op_ok | is_add | is_sub
                   | (is_div & (acc_b == '0));
    end

    always_comb begin
        sum_ab   = {1'b0, acc_a} + {1'b0, acc_b};
        a_ge_b   = acc_a >= acc_b;
        diff_ab  = a_ge_b ? acc_a - acc_b : acc_b - acc_a;
        prod_nxt = prod + (acc_b[0] ? mcand : '0);
        shl      = {rem, quo[OW-1]};
        q_bit    = shl >= {1'b0, acc_b};
        dif      = shl[OW-1:0] - acc_b;
        rem_nxt  = q_bit ? dif : shl[OW-1:0];
        quo_nxt  = {quo[OW-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_CONV;
            S_CONV: begin
                busy = 1'b1;
                if (conv_last) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (short_path || exec_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            quo       <= '0;
            rem       <= '0;
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            result    <= '0;
            remainder <= '0;
            neg       <= 1'b0;
            err_div0  <= 1'b0;
            err_dig   <= 1'b0;
            err_op    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    op_q      <= op;
                    a_q       <= a_dig;
                    b_q       <= b_dig;
                    acc_a     <= '0;
                    acc_b     <= '0;
                    cnt       <= '0;
                    result    <= '0;
                    remainder <= '0;
                    neg       <= 1'b0;
                    err_div0  <= 1'b0;
                    err_dig   <= 1'b0;
                    err_op    <= 1'b0;
                end
                S_CONV: begin
                    a_q   <= a_q << 8;
                    b_q   <= b_q << 8;
                    acc_a <= acc_a_nxt;
                    acc_b <= acc_b_nxt;
                    if (bad_a || bad_b) err_dig <= 1'b1;
                    // Preload the iterative datapath; the last digit wins.
                    mcand <= RW'(acc_a_nxt);
                    quo   <= acc_a_nxt;
                    prod  <= '0;
                    rem   <= '0;
                    cnt   <= conv_last ? '0 : cnt + 1'b1;
                end
                S_EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (err_dig || !op_ok) begin
                        err_op <= ~op_ok;
                    end else if (is_div && acc_b == '0) begin
                        err_div0 <= 1'b1;
                    end else if (is_add) begin
                        result <= RW'(sum_ab);
                    end else if (is_sub) begin
                        result <= RW'(diff_ab);
                        neg    <= ~a_ge_b;
                    end else if (is_mul) begin
                        prod  <= prod_nxt;
                        mcand <= mcand << 1;
                        acc_b <= acc_b >> 1;
                        if (exec_last) result <= prod_nxt;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        if (exec_last) begin
                            result    <= RW'(quo_nxt);
                            remainder <= rem_nxt;
                        end
                    end
                end
                S_DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc_unit.sv
// Bench for seq_calc_unit: arithmetic reference model with a per-cycle
// compare process, plus directed operations with literal expectations.
module tb_seq_calc_unit;

    localparam int NDIG = 2;
    localparam int OW   = 7;
    localparam int RW   = 14;
    localparam logic [7:0] ADD = 8'h2B;
    localparam logic [7:0] SUB = 8'h2D;
    localparam logic [7:0] MUL = 8'h2A;
    localparam logic [7:0] DIV = 8'h2F;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        op = ADD;
    logic [NDIG*8-1:0] a_dig = '0;
    logic [NDIG*8-1:0] b_dig = '0;
    logic              busy, done, neg, err_div0, err_dig, err_op;
    logic [RW-1:0]     result;
    logic [OW-1:0]     remainder;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_calc_unit #(.NDIG(NDIG), .OW(OW), .RW(RW),
                    .OP_ADD(ADD), .OP_SUB(SUB),
                    .OP_MUL(MUL), .OP_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_dig(a_dig), .b_dig(b_dig),
        .busy(busy), .done(done), .result(result),
        .remainder(remainder), .neg(neg), .err_div0(err_div0),
        .err_dig(err_dig), .err_op(err_op)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dg(int v);
        dg = {8'(v / 10), 8'(v % 10)};
    endfunction

    typedef struct {
        int res;
        int rem;
        bit neg;
        bit e0;
        bit ed;
        bit eo;
        int lat;
    } exp_t;

    function automatic exp_t model(logic [NDIG*8-1:0] a, logic [NDIG*8-1:0] b,
                                   logic [7:0] o);
        exp_t e;
        int av = 0;
        int bv = 0;
        e.res = 0; e.rem = 0; e.neg = 0; e.e0 = 0; e.ed = 0; e.eo = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (a[8*i +: 8] > 8'd9) e.ed = 1; else av = av * 10 + int'(a[8*i +: 8]);
            if (b[8*i +: 8] > 8'd9) e.ed = 1; else bv = bv * 10 + int'(b[8*i +: 8]);
        end
        e.eo  = !(o == ADD || o == SUB || o == MUL || o == DIV);
        e.lat = NDIG + 1;
        if (e.ed || e.eo) begin
        end else if (o == DIV && bv == 0) begin
            e.e0 = 1;
        end else if (o == ADD) begin
            e.res = av + bv;
        end else if (o == SUB) begin
            e.res = (av >= bv) ? av - bv : bv - av;
            e.neg = av < bv;
        end else if (o == MUL) begin
            e.res = av * bv;
            e.lat = NDIG + OW;
        end else begin
            e.res = av / bv;
            e.rem = av % bv;
            e.lat = NDIG + OW;
        end
        return e;
    endfunction

    // Timeline model: 0 idle, 1 busy, 2 done cycle.
    int   ph = 0;
    int   left = 0;
    exp_t pend;
    exp_t vis;
    bit   m_busy = 0;
    bit   m_done = 0;

    initial begin
        vis.res = 0; vis.rem = 0; vis.neg = 0;
        vis.e0 = 0; vis.ed = 0; vis.eo = 0; vis.lat = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; m_busy = 0; m_done = 0;
            vis.res = 0; vis.rem = 0; vis.neg = 0;
            vis.e0 = 0; vis.ed = 0; vis.eo = 0;
        end else if (ph == 0) begin
            if (start) begin
                pend = model(a_dig, b_dig, op);
                vis.res = 0; vis.rem = 0; vis.neg = 0;
                vis.e0 = 0; vis.ed = 0; vis.eo = 0;
                left = pend.lat;
                m_busy = 1;
                ph = 1;
            end
        end else if (ph == 1) begin
            left--;
            if (left == 0) begin
                vis = pend;
                m_busy = 0;
                m_done = 1;
                ph = 2;
            end
        end else begin
            m_done = 0;
            ph = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy) begin
                chk("result", result, vis.res);
                chk("remainder", remainder, vis.rem);
                chk("neg", neg, vis.neg);
                chk("err_div0", err_div0, vis.e0);
                chk("err_dig", err_dig, vis.ed);
                chk("err_op", err_op, vis.eo);
            end
        end
    end

    task automatic run_op(string nm, logic [15:0] a, logic [15:0] b,
                          logic [7:0] o, int xr, int xrem, bit xneg,
                          bit x0, bit xd, bit xo, int xlat, int pulse);
        int lat = -1;
        int bcnt = 0;
        repeat (2) @(negedge clk);
        a_dig = a; b_dig = b; op = o; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (busy) bcnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == pulse) begin
                start = 1'b1; a_dig = 16'h0303; b_dig = 16'h0909; op = ADD;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk({nm, " latency"}, lat, xlat);
        chk({nm, " busy cycles"}, bcnt, xlat);
        chk({nm, " result"}, result, xr);
        chk({nm, " remainder"}, remainder, xrem);
        chk({nm, " neg"}, neg, xneg);
        chk({nm, " err_div0"}, err_div0, x0);
        chk({nm, " err_dig"}, err_dig, xd);
        chk({nm, " err_op"}, err_op, xo);
    endtask

    initial begin
        int dcnt;
        int hit;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset flags", {neg, err_div0, err_dig, err_op}, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op("add 12+34", dg(12), dg(34), ADD, 46, 0, 0, 0, 0, 0, 3, 0);
        run_op("sub 05-17", dg(5), dg(17), SUB, 12, 0, 1, 0, 0, 0, 3, 0);
        run_op("sub 17-05", dg(17), dg(5), SUB, 12, 0, 0, 0, 0, 0, 3, 0);
        run_op("sub 40-40", dg(40), dg(40), SUB, 0, 0, 0, 0, 0, 0, 3, 0);
        run_op("mul 99*99", dg(99), dg(99), MUL, 9801, 0, 0, 0, 0, 0, 9, 0);
        run_op("div 87/09", dg(87), dg(9), DIV, 9, 6, 0, 0, 0, 0, 9, 0);
        run_op("div 87/00", dg(87), dg(0), DIV, 0, 0, 0, 1, 0, 0, 3, 0);
        run_op("div 07/08", dg(7), dg(8), DIV, 0, 7, 0, 0, 0, 0, 9, 0);
        run_op("div 99/01", dg(99), dg(1), DIV, 99, 0, 0, 0, 0, 0, 9, 0);
        run_op("bad digit", 16'h010C, dg(3), ADD, 0, 0, 0, 0, 1, 0, 3, 0);
        run_op("bad op", dg(12), dg(3), 8'h55, 0, 0, 0, 0, 0, 1, 3, 0);
        run_op("mul pulse", dg(23), dg(45), MUL, 1035, 0, 0, 0, 0, 0, 9, 2);
        run_op("add after", dg(0), dg(0), ADD, 0, 0, 0, 0, 0, 0, 3, 0);

        // Reset sampled at edge 4 of a multiply.
        repeat (2) @(negedge clk);
        a_dig = dg(99); b_dig = dg(99); op = MUL; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort result", result, 0);
        chk("abort remainder", remainder, 0);
        chk("abort flags", {neg, err_div0, err_dig, err_op}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dcnt = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort no done", dcnt, 0);

        // Start held high: re-accepted right after the done cycle.
        @(negedge clk);
        a_dig = dg(12); b_dig = dg(34); op = ADD; start = 1'b1;
        @(posedge clk);
        #1 b_dig = dg(5);
        hit = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin hit = k; break; end
        end
        chk("b2b first latency", hit, 3);
        chk("b2b first result", result, 46);
        hit = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (busy) start = 1'b0;
            if (done) begin hit = k; break; end
        end
        start = 1'b0;
        chk("b2b second latency", hit, 5);
        chk("b2b second result", result, 17);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
